// File: rtl/uart_frame_rx_ctrl_if.sv
// Byte-stream bundle between the UART receiver, the frame controller and the downstream consumer.
// rx_valid/rx_data is a 1-cycle strobe with no backpressure. out_* is valid/ready: a beat transfers on a clock edge where out_valid && out_ready; while out_valid && !out_ready, out_data/out_last hold.
interface uart_frame_rx_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output rx_valid, rx_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  rx_valid, rx_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/uart_frame_rx_ctrl.sv
// Frame controller: hunts SYNC, collects CMD/LEN/payload/CSUM, validates and replays the frame as a byte stream.
// Optional inter-byte timeout is enabled by defining UART_FRAMER_TIMEOUT_EN.
module uart_frame_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_frame_rx_ctrl_if.slave        bus,
  output logic                       busy_o,
  output logic                       frame_ok_o,
  output logic                       err_csum_o,
  output logic                       err_len_o,
  output logic                       err_timeout_o,
  output logic                       rx_dropped_o,
  output logic [2:0]                 state_o
);
  localparam int DEPTH = MAX_PAYLOAD + 2;
  localparam int IW    = $clog2(MAX_PAYLOAD + 1);
  localparam int RW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     len_q, len_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [RW-1:0]  rd_q, rd_d;
  logic [7:0]     buf_q [DEPTH];
  logic           wr_en;
  logic [RW-1:0]  wr_addr;
  logic           frame_ok_q, frame_ok_d;
  logic           err_csum_q, err_csum_d;
  logic           err_len_q, err_len_d;
  logic           drop_q, drop_d;

  logic in_frame, tmo_hit, beat_fire, last_beat, len_ok, csum_ok, pay_done;

  assign in_frame  = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign beat_fire = bus.out_valid && bus.out_ready;
  assign last_beat = (9'(rd_q) == (9'(len_q) + 9'd1));
  assign len_ok    = (bus.rx_data <= 8'(MAX_PAYLOAD));
  assign csum_ok   = ((sum_q + bus.rx_data) == 8'd0);
  assign pay_done  = (8'(idx_q) == (len_q - 8'd1));

`ifdef UART_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_tmo_q;

  // Counts idle cycles inside a frame; zero outside so every entry starts fresh.
  always_comb begin
    tmo_d = '0;
    if (in_frame && !bus.rx_valid) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = in_frame && !bus.rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= tmo_hit;
    end
  end

  assign err_timeout_o = err_tmo_q;
`else
  assign tmo_hit       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HUNT:    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = S_CMD;
      S_CMD:     if (bus.rx_valid) state_d = S_LEN;
                 else if (tmo_hit) state_d = S_HUNT;
      S_LEN:     if (bus.rx_valid) begin
                   if (!len_ok)                  state_d = S_HUNT;
                   else if (bus.rx_data == 8'd0) state_d = S_CSUM;
                   else                          state_d = S_PAYLOAD;
                 end else if (tmo_hit) state_d = S_HUNT;
      S_PAYLOAD: if (bus.rx_valid) begin
                   if (pay_done) state_d = S_CSUM;
                 end else if (tmo_hit) state_d = S_HUNT;
      S_CSUM:    if (bus.rx_valid) state_d = csum_ok ? S_DRAIN : S_HUNT;
                 else if (tmo_hit) state_d = S_HUNT;
      S_DRAIN:   if (beat_fire && last_beat) state_d = S_HUNT;
      default:   state_d = S_HUNT;
    endcase
  end

  always_comb begin
    sum_d      = sum_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    frame_ok_d = 1'b0;
    err_csum_d = 1'b0;
    err_len_d  = 1'b0;
    drop_d     = 1'b0;
    unique case (state_q)
      S_CMD: if (bus.rx_valid) begin
        wr_en = 1'b1;
        sum_d = bus.rx_data;
      end
      S_LEN: if (bus.rx_valid) begin
        if (!len_ok) begin
          err_len_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = RW'(1);
          sum_d   = sum_q + bus.rx_data;
          len_d   = bus.rx_data;
          idx_d   = '0;
        end
      end
      S_PAYLOAD: if (bus.rx_valid) begin
        wr_en   = 1'b1;
        wr_addr = RW'(idx_q) + RW'(2);
        sum_d   = sum_q + bus.rx_data;
        idx_d   = idx_q + 1'b1;
      end
      S_CSUM: if (bus.rx_valid) begin
        frame_ok_d = csum_ok;
        err_csum_d = !csum_ok;
        rd_d       = '0;
      end
      S_DRAIN: begin
        if (beat_fire)    rd_d   = rd_q + 1'b1;
        if (bus.rx_valid) drop_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rd_q       <= '0;
      frame_ok_q <= 1'b0;
      err_csum_q <= 1'b0;
      err_len_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rd_q       <= rd_d;
      frame_ok_q <= frame_ok_d;
      err_csum_q <= err_csum_d;
      err_len_q  <= err_len_d;
      drop_q     <= drop_d;
    end
  end

  // Frame storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= bus.rx_data;
  end

  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = bus.out_valid ? buf_q[rd_q] : 8'd0;
  assign bus.out_last  = bus.out_valid && last_beat;
  assign busy_o        = (state_q != S_HUNT);
  assign frame_ok_o    = frame_ok_q;
  assign err_csum_o    = err_csum_q;
  assign err_len_o     = err_len_q;
  assign rx_dropped_o  = drop_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Randomized bench for uart_frame_rx_ctrl against a frame-level reference model (expected beats and pulses).
module tb_uart_frame_rx_ctrl;
  localparam int MAXP = 16;
  localparam int TMO  = 50;
  localparam int EV_OK = 1, EV_CSUM = 2, EV_LEN = 3, EV_TMO = 4, EV_DROP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_rx_ctrl_if bus();
  logic       busy, frame_ok, err_csum, err_len, err_timeout, rx_dropped;
  logic [2:0] state;

  uart_frame_rx_ctrl #(.SYNC_BYTE(8'hA5), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy_o(busy), .frame_ok_o(frame_ok), .err_csum_o(err_csum), .err_len_o(err_len),
    .err_timeout_o(err_timeout), .rx_dropped_o(rx_dropped), .state_o(state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { int code; int cyc; } ev_t;
  ev_t        exp_ev_q[$];
  logic [8:0] exp_q[$];
  int         rdy_mode = 0;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Scoreboard: beats, held data under backpressure, pulse code and latency.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_beat;
  logic [8:0] mon_x;
  ev_t        mon_e;
  int         pc;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_beat", {bus.out_last, bus.out_data}, prev_beat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("beat_unexpected", {bus.out_last, bus.out_data}, 9'h1ff);
        else begin
          mon_x = exp_q.pop_front();
          check("beat", {bus.out_last, bus.out_data}, mon_x);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_beat  = {bus.out_last, bus.out_data};
      pc = frame_ok ? EV_OK : err_csum ? EV_CSUM : err_len ? EV_LEN :
           err_timeout ? EV_TMO : rx_dropped ? EV_DROP : 0;
      if (pc != 0) begin
        check("pulse_onehot", $countones({frame_ok, err_csum, err_len, err_timeout, rx_dropped}), 1);
        if (exp_ev_q.size() == 0) check("pulse_unexpected", pc, 0);
        else begin
          mon_e = exp_ev_q.pop_front();
          check("pulse_code", pc, mon_e.code);
          check("pulse_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int code, input int extra);
    ev_t e;
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (code != 0) begin
      e.code = code;
      e.cyc  = cyc + 1 + extra;
      exp_ev_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] non_sync();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return (b == 8'hA5) ? 8'h5A : b;
  endfunction

  // Reference model: outcome of a whole frame from the framing and checksum rules.
  task automatic play_frame(input logic [7:0] f[$], input int stall_at);
    int len, term, outcome, tmo_case, code, extra;
    logic [7:0] sum;
    len      = int'(f[2]);
    term     = (len > MAXP) ? 2 : len + 3;
    tmo_case = 0;
`ifdef UART_FRAMER_TIMEOUT_EN
    if (stall_at >= 0 && stall_at < term) tmo_case = 1;
`endif
    sum = 8'd0;
    if (len <= MAXP) for (int i = 1; i <= term; i++) sum = sum + f[i];
    outcome = (len > MAXP) ? EV_LEN : (sum == 8'd0) ? EV_OK : EV_CSUM;
    if (!tmo_case && outcome == EV_OK)
      for (int i = 1; i <= len + 2; i++) exp_q.push_back({(i == len + 2), f[i]});
    for (int i = 0; i < f.size(); i++) begin
      code  = 0;
      extra = 0;
      if (tmo_case) begin
        if (i == stall_at) begin code = EV_TMO; extra = TMO; end
      end else if (i == term) code = outcome;
      send_byte(f[i], code, extra);
      if (i == 0) check("busy_after_sync", busy, 1);
      if (i == stall_at) begin
        repeat (TMO + 10) @(posedge clk);
`ifndef UART_FRAMER_TIMEOUT_EN
        check("busy_waits_forever", busy, 1);
`endif
      end else repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", busy, 0);
    check("beats_left", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int i = 0;
    while (!bus.out_valid && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("drain_started", bus.out_valid, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [7:0] f[$];
  int         len, kind;
  logic [7:0] sum;

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pulses", {frame_ok, err_csum, err_len, err_timeout, rx_dropped}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame, LEN==0 frame, bad checksum then recovery, oversize LEN, LEN at the limit.
    f = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCA};
    play_frame(f, -1); wait_idle();
    f = '{8'hA5, 8'h07, 8'h00, 8'hF9};
    play_frame(f, -1); wait_idle();
    f = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCB};
    play_frame(f, -1); wait_idle();
    check("no_drain_after_bad_csum", bus.out_valid, 0);
    f = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCA};
    play_frame(f, -1); wait_idle();
    f = '{8'hA5, 8'h03, 8'h11, 8'h01, 8'h02, 8'h03};
    play_frame(f, -1); wait_idle();
    f = '{8'hA5, 8'hA5, 8'h10};
    sum = 8'hB5;
    for (int i = 0; i < MAXP; i++) begin
      f.push_back((i == 3) ? 8'hA5 : 8'(i * 7 + 1));
      sum = sum + f[f.size() - 1];
    end
    f.push_back(8'd0 - sum);
    play_frame(f, -1); wait_idle();

    // Backpressure mid-drain with bytes (including SYNC) arriving and being dropped.
    rdy_mode = 2;
    f = '{8'hA5, 8'h02, 8'h02, 8'h33, 8'h44, 8'h85};
    play_frame(f, -1);
    wait_out_valid();
    send_byte(8'h5A, EV_DROP, 0);
    send_byte(8'hA5, EV_DROP, 0);
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    wait_idle();

    // Long silence mid-frame: timeout when enabled, otherwise the frame completes.
    f = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'hCA};
    play_frame(f, 1); wait_idle();

    // Reset while draining aborts the stream without a pulse.
    rdy_mode = 2;
    f = '{8'hA5, 8'h04, 8'h01, 8'h9B, 8'h60};
    play_frame(f, -1);
    wait_out_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_drain_out_valid", bus.out_valid, 0);
    check("rst_drain_busy", busy, 0);
    rdy_mode = 0;
    f = '{8'hA5, 8'h07, 8'h00, 8'hF9};
    play_frame(f, -1); wait_idle();

    // Random frames with random downstream readiness.
    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) send_byte(non_sync(), 0, 0);
      kind = $urandom_range(0, 9);
      len  = (kind == 3) ? 0 : (kind == 4) ? MAXP : $urandom_range(1, MAXP);
      f = '{8'hA5, 8'($urandom_range(0, 255))};
      if (kind == 2) begin
        f.push_back(8'($urandom_range(MAXP + 1, 255)));
        repeat ($urandom_range(0, 4)) f.push_back(non_sync());
      end else begin
        f.push_back(8'(len));
        for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
        sum = 8'd0;
        for (int i = 1; i < f.size(); i++) sum = sum + f[i];
        if (kind <= 1) f.push_back(8'd0 - sum + 8'($urandom_range(1, 255)));
        else           f.push_back(8'd0 - sum);
      end
      play_frame(f, -1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("events_left", exp_ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
